// File: rtl/mem_arbiter_if.sv
// Request/completion bundle between the three memory clients, the arbiter and the memory controller.
// master is the arbiter's view; slave is the view of the clients and controller around it.
interface mem_arbiter_if;
    logic        lsb_valid;
    logic        lsb_wr;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic [2:0]  lsb_len;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        pf_valid;
    logic [31:0] pf_addr;
    logic        pf_done;
    logic [31:0] pf_rdata;
    logic        mc_valid;
    logic        mc_wr;
    logic [31:0] mc_addr;
    logic [31:0] mc_wdata;
    logic [2:0]  mc_len;
    logic        mc_done;
    logic [31:0] mc_rdata;

    modport master (
        input  lsb_valid, lsb_wr, lsb_addr, lsb_wdata, lsb_len,
        input  if_valid, if_addr, pf_valid, pf_addr,
        input  mc_done, mc_rdata,
        output lsb_done, lsb_rdata, if_done, if_rdata, pf_done, pf_rdata,
        output mc_valid, mc_wr, mc_addr, mc_wdata, mc_len
    );

    modport slave (
        output lsb_valid, lsb_wr, lsb_addr, lsb_wdata, lsb_len,
        output if_valid, if_addr, pf_valid, pf_addr,
        output mc_done, mc_rdata,
        input  lsb_done, lsb_rdata, if_done, if_rdata, pf_done, pf_rdata,
        input  mc_valid, mc_wr, mc_addr, mc_wdata, mc_len
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the memory controller port between LSB, instruction fetch and prefetch with starvation guard.
// state | meaning
// IDLE  | arbitrate eligible requests, latch the winner
// BUSY  | request held toward controller until mc_done or abort
// GAP   | done pulse visible, owner released; no arbitration
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          io_buffer_full,
    input  logic          clear,
    mem_arbiter_if.master bus,
    output logic [1:0]    owner
);
    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_LSB  = 2'd1;
    localparam logic [1:0] OWN_IF   = 2'd2;
    localparam logic [1:0] OWN_PF   = 2'd3;
    localparam logic [CNT_WIDTH-1:0] STARVE_MAX = CNT_WIDTH'(STARVE_LIMIT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [1:0]             owner_q, owner_d;
    logic                   mc_valid_q, mc_valid_d;
    logic                   mc_wr_q, mc_wr_d;
    logic [31:0]            mc_addr_q, mc_addr_d;
    logic [31:0]            mc_wdata_q, mc_wdata_d;
    logic [2:0]             mc_len_q, mc_len_d;
    logic                   lsb_done_q, lsb_done_d;
    logic                   if_done_q, if_done_d;
    logic                   pf_done_q, pf_done_d;
    logic [31:0]            lsb_rdata_q, lsb_rdata_d;
    logic [31:0]            if_rdata_q, if_rdata_d;
    logic [31:0]            pf_rdata_q, pf_rdata_d;
    logic [CNT_WIDTH-1:0]   if_cnt_q, if_cnt_d;
    logic [CNT_WIDTH-1:0]   pf_cnt_q, pf_cnt_d;

    logic       lsb_elig, if_elig, pf_elig;
    logic [1:0] grant;
    logic       owner_valid;

    // Stores into the UART window are held back while its buffer cannot accept them.
    assign lsb_elig = bus.lsb_valid &&
                      !(bus.lsb_wr && (bus.lsb_addr[17:16] == 2'b11) && io_buffer_full);
    assign if_elig  = bus.if_valid && !clear;
    assign pf_elig  = bus.pf_valid && !clear;

    always_comb begin
        grant = OWN_NONE;
        if (if_elig && (if_cnt_q == STARVE_MAX))      grant = OWN_IF;
        else if (pf_elig && (pf_cnt_q == STARVE_MAX)) grant = OWN_PF;
        else if (lsb_elig)                            grant = OWN_LSB;
        else if (if_elig)                             grant = OWN_IF;
        else if (pf_elig)                             grant = OWN_PF;
    end

    always_comb begin
        owner_valid = 1'b0;
        case (owner_q)
            OWN_LSB: owner_valid = bus.lsb_valid;
            OWN_IF:  owner_valid = bus.if_valid;
            OWN_PF:  owner_valid = bus.pf_valid;
            default: owner_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mc_valid_d  = mc_valid_q;
        mc_wr_d     = mc_wr_q;
        mc_addr_d   = mc_addr_q;
        mc_wdata_d  = mc_wdata_q;
        mc_len_d    = mc_len_q;
        lsb_done_d  = lsb_done_q;
        if_done_d   = if_done_q;
        pf_done_d   = pf_done_q;
        lsb_rdata_d = lsb_rdata_q;
        if_rdata_d  = if_rdata_q;
        pf_rdata_d  = pf_rdata_q;
        if_cnt_d    = if_cnt_q;
        pf_cnt_d    = pf_cnt_q;

        if (rdy) begin
            if (!bus.if_valid) if_cnt_d = '0;
            if (!bus.pf_valid) pf_cnt_d = '0;

            case (state_q)
                IDLE: begin
                    if (grant != OWN_NONE) begin
                        state_d    = BUSY;
                        owner_d    = grant;
                        mc_valid_d = 1'b1;
                        if (grant == OWN_LSB) begin
                            mc_wr_d    = bus.lsb_wr;
                            mc_addr_d  = bus.lsb_addr;
                            mc_wdata_d = bus.lsb_wdata;
                            mc_len_d   = bus.lsb_len;
                        end else begin
                            mc_wr_d    = 1'b0;
                            mc_addr_d  = (grant == OWN_IF) ? bus.if_addr : bus.pf_addr;
                            mc_wdata_d = '0;
                            mc_len_d   = 3'd4;
                        end
                        if (grant == OWN_IF)
                            if_cnt_d = '0;
                        else if (if_elig && (if_cnt_q != STARVE_MAX))
                            if_cnt_d = if_cnt_q + CNT_ONE;
                        if (grant == OWN_PF)
                            pf_cnt_d = '0;
                        else if (pf_elig && (pf_cnt_q != STARVE_MAX))
                            pf_cnt_d = pf_cnt_q + CNT_ONE;
                    end
                end
                BUSY: begin
                    // Completion takes precedence over an abort seen in the same cycle.
                    if (bus.mc_done) begin
                        state_d    = GAP;
                        mc_valid_d = 1'b0;
                        case (owner_q)
                            OWN_LSB: begin lsb_done_d = 1'b1; lsb_rdata_d = bus.mc_rdata; end
                            OWN_IF:  begin if_done_d  = 1'b1; if_rdata_d  = bus.mc_rdata; end
                            OWN_PF:  begin pf_done_d  = 1'b1; pf_rdata_d  = bus.mc_rdata; end
                            default: ;
                        endcase
                    end else if (!owner_valid || (clear && (owner_q != OWN_LSB))) begin
                        state_d    = GAP;
                        mc_valid_d = 1'b0;
                    end
                end
                GAP: begin
                    state_d    = IDLE;
                    owner_d    = OWN_NONE;
                    lsb_done_d = 1'b0;
                    if_done_d  = 1'b0;
                    pf_done_d  = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            mc_valid_q  <= 1'b0;
            mc_wr_q     <= 1'b0;
            mc_addr_q   <= '0;
            mc_wdata_q  <= '0;
            mc_len_q    <= '0;
            lsb_done_q  <= 1'b0;
            if_done_q   <= 1'b0;
            pf_done_q   <= 1'b0;
            lsb_rdata_q <= '0;
            if_rdata_q  <= '0;
            pf_rdata_q  <= '0;
            if_cnt_q    <= '0;
            pf_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mc_valid_q  <= mc_valid_d;
            mc_wr_q     <= mc_wr_d;
            mc_addr_q   <= mc_addr_d;
            mc_wdata_q  <= mc_wdata_d;
            mc_len_q    <= mc_len_d;
            lsb_done_q  <= lsb_done_d;
            if_done_q   <= if_done_d;
            pf_done_q   <= pf_done_d;
            lsb_rdata_q <= lsb_rdata_d;
            if_rdata_q  <= if_rdata_d;
            pf_rdata_q  <= pf_rdata_d;
            if_cnt_q    <= if_cnt_d;
            pf_cnt_q    <= pf_cnt_d;
        end
    end

    assign owner         = owner_q;
    assign bus.mc_valid  = mc_valid_q;
    assign bus.mc_wr     = mc_wr_q;
    assign bus.mc_addr   = mc_addr_q;
    assign bus.mc_wdata  = mc_wdata_q;
    assign bus.mc_len    = mc_len_q;
    assign bus.lsb_done  = lsb_done_q;
    assign bus.if_done   = if_done_q;
    assign bus.pf_done   = pf_done_q;
    assign bus.lsb_rdata = lsb_rdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.pf_rdata  = pf_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays all three clients and the memory controller.
module tb_mem_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       rdy;
    logic       io_buffer_full;
    logic       clear;
    logic [1:0] owner;
    int         vectors = 0;
    int         miscompares = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIMIT(4), .CNT_WIDTH(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .io_buffer_full (io_buffer_full),
        .clear          (clear),
        .bus            (bus),
        .owner          (owner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic lsb_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] len);
        bus.lsb_valid = 1'b1;
        bus.lsb_wr    = wr;
        bus.lsb_addr  = addr;
        bus.lsb_wdata = wdata;
        bus.lsb_len   = len;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0; clear = 1'b0;
        bus.lsb_valid = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_addr = '0; bus.lsb_wdata = '0; bus.lsb_len = '0;
        bus.if_valid = 1'b0; bus.if_addr = '0; bus.pf_valid = 1'b0; bus.pf_addr = '0;
        bus.mc_done = 1'b0; bus.mc_rdata = '0;
        tick(); tick();
        chk("rst_owner", 32'(owner), 0);
        chk("rst_mc_valid", 32'(bus.mc_valid), 0);
        chk("rst_mc_len", 32'(bus.mc_len), 0);
        chk("rst_mc_addr", bus.mc_addr, 0);
        chk("rst_lsb_done", 32'(bus.lsb_done), 0);
        chk("rst_lsb_rdata", bus.lsb_rdata, 0);
        rst = 1'b1;
        tick();

        // LSB load, len 2
        lsb_req(1'b0, 32'h1000, 32'h0, 3'd2);
        tick();
        chk("ld_owner", 32'(owner), 1);
        chk("ld_mc_valid", 32'(bus.mc_valid), 1);
        chk("ld_mc_addr", bus.mc_addr, 32'h1000);
        chk("ld_mc_len", 32'(bus.mc_len), 2);
        chk("ld_mc_wr", 32'(bus.mc_wr), 0);
        bus.mc_done = 1'b1; bus.mc_rdata = 32'h0000BEEF;
        tick();
        chk("ld_lsb_done", 32'(bus.lsb_done), 1);
        chk("ld_lsb_rdata", bus.lsb_rdata, 32'h0000BEEF);
        chk("ld_if_done", 32'(bus.if_done), 0);
        chk("ld_pf_done", 32'(bus.pf_done), 0);
        chk("ld_mc_valid_off", 32'(bus.mc_valid), 0);
        bus.mc_done = 1'b0; bus.lsb_valid = 1'b0;
        tick();
        chk("ld_done_pulse", 32'(bus.lsb_done), 0);
        chk("ld_owner_rel", 32'(owner), 0);

        // All three requesting at once
        lsb_req(1'b0, 32'h2000, 32'h0, 3'd4);
        bus.if_valid = 1'b1; bus.if_addr = 32'h100;
        bus.pf_valid = 1'b1; bus.pf_addr = 32'h200;
        tick();
        chk("pri_1st_lsb", 32'(owner), 1);
        bus.mc_done = 1'b1; bus.mc_rdata = 32'h11;
        tick();
        chk("pri_lsb_done", 32'(bus.lsb_done), 1);
        bus.mc_done = 1'b0; bus.lsb_valid = 1'b0;
        tick();
        chk("pri_gap_owner", 32'(owner), 0);
        tick();
        chk("pri_2nd_if", 32'(owner), 2);
        chk("pri_if_len", 32'(bus.mc_len), 4);
        chk("pri_if_addr", bus.mc_addr, 32'h100);
        bus.mc_done = 1'b1; bus.mc_rdata = 32'h22;
        tick();
        chk("pri_if_done", 32'(bus.if_done), 1);
        chk("pri_if_rdata", bus.if_rdata, 32'h22);
        chk("pri_lsb_rdata_hold", bus.lsb_rdata, 32'h11);
        chk("pri_if_lsb_done", 32'(bus.lsb_done), 0);
        bus.mc_done = 1'b0; bus.if_valid = 1'b0;
        tick(); tick();
        chk("pri_3rd_pf", 32'(owner), 3);
        chk("pri_pf_len", 32'(bus.mc_len), 4);
        chk("pri_pf_addr", bus.mc_addr, 32'h200);
        bus.mc_done = 1'b1; bus.mc_rdata = 32'h33;
        tick();
        chk("pri_pf_done", 32'(bus.pf_done), 1);
        chk("pri_pf_rdata", bus.pf_rdata, 32'h33);
        bus.mc_done = 1'b0; bus.pf_valid = 1'b0;
        tick();

        // Starvation: IF passed over four times, fifth grant is forced to IF
        bus.if_valid = 1'b1; bus.if_addr = 32'h300;
        lsb_req(1'b1, 32'h4000, 32'hA5, 3'd4);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stv_lsb_grant", 32'(owner), 1);
            bus.mc_done = 1'b1;
            tick();
            bus.mc_done = 1'b0; bus.lsb_valid = 1'b0;
            tick();
            bus.lsb_valid = 1'b1;
        end
        tick();
        chk("stv_forced_if", 32'(owner), 2);
        bus.mc_done = 1'b1; bus.mc_rdata = 32'h44;
        tick();
        chk("stv_if_done", 32'(bus.if_done), 1);
        chk("stv_lsb_done", 32'(bus.lsb_done), 0);
        bus.mc_done = 1'b0; bus.if_valid = 1'b0;
        tick(); tick();
        chk("stv_lsb_after", 32'(owner), 1);
        bus.mc_done = 1'b1;
        tick();
        chk("stv_lsb_fin", 32'(bus.lsb_done), 1);
        bus.mc_done = 1'b0; bus.lsb_valid = 1'b0;
        tick();

        // UART-bound store skipped while buffer full
        lsb_req(1'b1, 32'h30000, 32'h55, 3'd1);
        io_buffer_full = 1'b1;
        bus.if_valid = 1'b1; bus.if_addr = 32'h400;
        tick();
        chk("uart_if_first", 32'(owner), 2);
        bus.mc_done = 1'b1; bus.mc_rdata = 32'h66;
        tick();
        chk("uart_if_done", 32'(bus.if_done), 1);
        bus.mc_done = 1'b0; bus.if_valid = 1'b0;
        tick(); tick();
        chk("uart_blocked_owner", 32'(owner), 0);
        chk("uart_blocked_valid", 32'(bus.mc_valid), 0);
        io_buffer_full = 1'b0;
        tick();
        chk("uart_lsb_owner", 32'(owner), 1);
        chk("uart_lsb_addr", bus.mc_addr, 32'h30000);
        chk("uart_lsb_wr", 32'(bus.mc_wr), 1);
        bus.mc_done = 1'b1;
        tick();
        chk("uart_lsb_done", 32'(bus.lsb_done), 1);
        bus.mc_done = 1'b0; bus.lsb_valid = 1'b0;
        tick();

        // clear aborts an in-flight fetch
        bus.if_valid = 1'b1; bus.if_addr = 32'h500;
        tick();
        chk("clr_if_owner", 32'(owner), 2);
        clear = 1'b1;
        tick();
        chk("clr_if_mc_valid", 32'(bus.mc_valid), 0);
        chk("clr_if_no_done", 32'(bus.if_done), 0);
        clear = 1'b0; bus.if_valid = 1'b0;
        tick();
        chk("clr_if_owner_rel", 32'(owner), 0);
        chk("clr_if_no_done2", 32'(bus.if_done), 0);

        // clear does not abort a committed store
        lsb_req(1'b1, 32'h6000, 32'hCAFE, 3'd4);
        tick();
        chk("clr_st_owner", 32'(owner), 1);
        chk("clr_st_wdata", bus.mc_wdata, 32'hCAFE);
        clear = 1'b1;
        tick();
        chk("clr_st_held", 32'(bus.mc_valid), 1);
        chk("clr_st_owner2", 32'(owner), 1);
        bus.mc_done = 1'b1;
        tick();
        chk("clr_st_done", 32'(bus.lsb_done), 1);
        bus.mc_done = 1'b0; clear = 1'b0; bus.lsb_valid = 1'b0;
        tick();

        // rdy low freezes a transaction in BUSY
        lsb_req(1'b0, 32'h7000, 32'h0, 3'd1);
        tick();
        chk("rdy_owner", 32'(owner), 1);
        rdy = 1'b0; bus.mc_done = 1'b1; bus.mc_rdata = 32'h77;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rdy_frz_valid", 32'(bus.mc_valid), 1);
            chk("rdy_frz_done", 32'(bus.lsb_done), 0);
            chk("rdy_frz_owner", 32'(owner), 1);
        end
        rdy = 1'b1;
        tick();
        chk("rdy_done", 32'(bus.lsb_done), 1);
        chk("rdy_rdata", bus.lsb_rdata, 32'h77);
        bus.mc_done = 1'b0; bus.lsb_valid = 1'b0;
        tick();
        chk("rdy_done_pulse", 32'(bus.lsb_done), 0);

        // owner drops valid: abort without done
        lsb_req(1'b0, 32'hA000, 32'h0, 3'd4);
        tick();
        chk("drop_owner", 32'(owner), 1);
        bus.lsb_valid = 1'b0;
        tick();
        chk("drop_mc_valid", 32'(bus.mc_valid), 0);
        chk("drop_no_done", 32'(bus.lsb_done), 0);
        tick();
        chk("drop_owner_rel", 32'(owner), 0);

        // mc_done and valid drop together: done wins
        lsb_req(1'b0, 32'h9000, 32'h0, 3'd4);
        tick();
        chk("race_owner", 32'(owner), 1);
        bus.lsb_valid = 1'b0; bus.mc_done = 1'b1; bus.mc_rdata = 32'h99;
        tick();
        chk("race_done", 32'(bus.lsb_done), 1);
        chk("race_rdata", bus.lsb_rdata, 32'h99);
        bus.mc_done = 1'b0;
        tick();
        chk("race_owner_rel", 32'(owner), 0);

        // async reset in the middle of a store
        lsb_req(1'b1, 32'h8000, 32'h88, 3'd4);
        tick();
        chk("arst_pre_owner", 32'(owner), 1);
        rst = 1'b0;
        #1;
        chk("arst_mc_valid", 32'(bus.mc_valid), 0);
        chk("arst_owner", 32'(owner), 0);
        chk("arst_lsb_done", 32'(bus.lsb_done), 0);
        chk("arst_mc_addr", bus.mc_addr, 0);
        bus.lsb_valid = 1'b0;
        tick();
        rst = 1'b1; bus.mc_done = 1'b1;
        tick();
        chk("arst_no_done", 32'(bus.lsb_done), 0);
        chk("arst_owner_idle", 32'(owner), 0);
        bus.mc_done = 1'b0;
        tick();
        chk("arst_no_done2", 32'(bus.lsb_done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-request memory controller port between three requesters: LSB (read/write, len 1/2/4), instruction fetch (4-byte read), and the next-line prefetcher (4-byte read).
- Fixed priority LSB > IF > PF, with a starvation guard so a lower client is never passed over more than STARVE_LIMIT times.
- Latches the winning request, holds it stable toward the controller until completion, then routes the read data and a done pulse back to the owner.
- Skips UART-bound LSB stores while the UART buffer is full.

Parameters:
STARVE_LIMIT, 4, number of grants a waiting IF/PF request may be passed over before it is forced to win
CNT_WIDTH, 3, width of the per-client pass-over counters; must hold STARVE_LIMIT

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
rdy  in  1  global pause; 0 freezes all state
io_buffer_full  in  1  UART buffer full
clear  in  1  pipeline flush; aborts in-flight IF/PF reads
lsb_valid, lsb_wr  in  1,1  LSB request, 1 = write
lsb_addr, lsb_wdata  in  32,32  LSB address / store data
lsb_len  in  3  access length 1, 2 or 4
lsb_done  out  1  one-cycle completion pulse
lsb_rdata  out  32  load data, valid with lsb_done
if_valid  in  1  fetch request
if_addr  in  32  fetch address
if_done  out  1  completion pulse
if_rdata  out  32  fetch data
pf_valid  in  1  prefetch request
pf_addr  in  32  prefetch address
pf_done  out  1  completion pulse
pf_rdata  out  32  prefetch data
mc_valid  out  1  request to memory controller
mc_wr  out  1  1 = write
mc_addr, mc_wdata  out  32,32  latched address / store data
mc_len  out  3  latched length; 4 for IF/PF
mc_done  in  1  controller completion pulse
mc_rdata  in  32  controller read data, valid with mc_done
owner  out  2  current grant: 0 none, 1 LSB, 2 IF, 3 PF

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; owner=0.
- Reset: all *_done, mc_valid, mc_wr = 0; mc_addr, mc_wdata, *_rdata = 0; mc_len = 0.
- Reset: pass-over counters = 0.
- Reset is honoured mid-transaction; no done is issued for an aborted transfer.
- rdy=0: no state, counter or output change; mc_valid holds its value.
- State IDLE, eligibility: LSB is eligible if lsb_valid and not (lsb_wr and lsb_addr[17:16]==2'b11 and io_buffer_full). IF and PF are eligible if their valid is high and clear=0.
- State IDLE, winner: the highest-priority starved client wins (IF before PF); otherwise fixed priority LSB > IF > PF.
- State IDLE, on a winner: latch wr/addr/wdata/len (IF/PF: wr=0, len=4); set owner; mc_valid=1 from the next cycle; go to BUSY.
- State IDLE, no eligible client: stay in IDLE.
- Starvation counters: at each grant, every other eligible IF/PF client that lost increments its counter (saturating at STARVE_LIMIT). A counter clears when its client is granted or its valid is low. A client is starved when its counter == STARVE_LIMIT.
- State BUSY, hold: request fields stay stable while mc_valid=1.
- State BUSY, on mc_done: next cycle the owner's done=1 and rdata=mc_rdata (rdata is don't-care for stores); mc_valid=0; go to GAP.
- State BUSY, owner's valid drops before mc_done: abort; next cycle mc_valid=0, no done; go to GAP.
- State BUSY, clear=1 with owner IF/PF: abort as above.
- State BUSY, clear=1 with owner LSB: no effect; committed stores must finish.
- Simultaneous mc_done and abort in the same cycle: mc_done wins; done is still pulsed.
- State GAP: all done=0; owner=0; go to IDLE. No arbitration in GAP. Requesters drop valid in the cycle they see done, so a finished request is never re-granted.
- Grant throughput: one grant per 3 cycles plus the controller's latency. A done pulse lasts exactly one cycle. At most one done is high per cycle.
- rdata registers hold their value until the next completion for that client.

Test Plan:
- Reset mid-BUSY (LSB store in flight), rst=0 for 1 cycle → mc_valid, lsb_done, owner immediately 0; no done after release.
- lsb_valid=if_valid=pf_valid=1 together, each held until its done → grants LSB, IF, PF in that order; mc_len = 4 for IF and PF.
- IF held and LSB re-requested 4 times, STARVE_LIMIT=4 → 5th grant goes to IF even though lsb_valid=1.
- LSB store to 0x30000, io_buffer_full=1, if_valid=1 → IF granted first; LSB granted after io_buffer_full falls.
- IF granted, clear=1 before mc_done → mc_valid=0 next cycle, if_done never pulses, owner returns to 0.
- LSB store granted, clear=1 → store completes.
- LSB load 0x1000 len=2, mc_done with mc_rdata=0x0000BEEF → one cycle later lsb_done=1, lsb_rdata=0x0000BEEF; if_done=pf_done=0.
- rdy=0 for 3 cycles during BUSY → all outputs frozen; transaction completes normally once rdy=1.
